// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, sequencer
// states and the datapath select codes driven by control_fsm.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_IMM    = 2'b01;
   localparam logic [1:0] PC_ALU    = 2'b10;

   localparam logic [1:0] ASRC_RS1  = 2'b00;
   localparam logic [1:0] ASRC_PC   = 2'b01;
   localparam logic [1:0] ASRC_ZERO = 2'b10;

   localparam logic [1:0] BSRC_RS2  = 2'b00;
   localparam logic [1:0] BSRC_IMM  = 2'b01;
   localparam logic [1:0] BSRC_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU    = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;

   // SYSTEM is decoded separately as a clean halt, so it is not listed here.
   function automatic logic is_rv32i_op(input logic [6:0] op);
      logic ok;
      case (op)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/branch_unit.sv
// Branch condition resolver: maps funct3 and the ALU compare flags to taken.
module branch_unit
   import rv32i_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken
);

   // funct3 010/011 are not branch encodings and never redirect the pc.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = lt;
         3'b101:  taken = ~lt;
         3'b110:  taken = ltu;
         3'b111:  taken = ~ltu;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky HALT,
// driving every datapath select and enable combinationally from state and ir.
module control_fsm
   import rv32i_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = 1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        alu_zero,
   input  logic        alu_lt,
   input  logic        alu_ltu,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_op,
   output logic        regfile_wren,
   output logic [1:0]  wb_sel,
   output logic        dmem_wren,
   output logic [2:0]  mem_funct3,
   output logic        halted,
   output logic        illegal
);

   localparam int                CNT_W   = $clog2(MEM_WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MEM_WAIT_CYCLES);

   state_t            state_r;
   state_t            state_next_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              halted_r;
   logic              illegal_r;
   logic              set_halt_s;
   logic              set_illegal_s;

   logic [6:0]        opcode_s;
   logic [2:0]        f3_s;
   logic [4:0]        rd_s;
   logic              last_s;
   logic              taken_s;
   logic              unused_ir_s;

   logic [1:0]        ex_a_s;
   logic [1:0]        ex_b_s;
   logic [3:0]        ex_op_s;

   logic              ir_we_s;
   logic              pc_we_s;
   logic [1:0]        pc_src_s;
   logic [1:0]        alu_src_a_s;
   logic [1:0]        alu_src_b_s;
   logic [3:0]        alu_op_s;
   logic              regfile_wren_s;
   logic [1:0]        wb_sel_s;
   logic              dmem_wren_s;
   logic [2:0]        mem_funct3_s;

   assign opcode_s    = ir[6:0];
   assign rd_s        = ir[11:7];
   assign f3_s        = ir[14:12];
   assign last_s      = (cnt_r == CNT_MAX);
   assign unused_ir_s = ^{ir[31], ir[29:15]};

   branch_unit u_branch_unit (
      .funct3 (f3_s),
      .zero   (alu_zero),
      .lt     (alu_lt),
      .ltu    (alu_ltu),
      .taken  (taken_s)
   );

   // ALU operand/op selection per instruction class; held from EXECUTE through MEM and WB.
   always_comb begin
      ex_a_s  = ASRC_RS1;
      ex_b_s  = BSRC_RS2;
      ex_op_s = ALU_ADD;
      case (opcode_s)
         OP_R: begin
            ex_op_s = {ir[30], f3_s};
         end
         OP_IMM: begin
            ex_b_s  = BSRC_IMM;
            ex_op_s = {ir[30] & (f3_s == 3'b101), f3_s};
         end
         OP_LOAD, OP_STORE, OP_JALR: begin
            ex_b_s  = BSRC_IMM;
         end
         OP_BRANCH: begin
            ex_op_s = ALU_SUB;
         end
         OP_AUIPC: begin
            ex_a_s  = ASRC_PC;
            ex_b_s  = BSRC_IMM;
         end
         default: begin
            ex_a_s  = ASRC_RS1;
         end
      endcase
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      state_next_s   = state_r;
      set_halt_s     = 1'b0;
      set_illegal_s  = 1'b0;
      ir_we_s        = 1'b0;
      pc_we_s        = 1'b0;
      pc_src_s       = PC_PLUS4;
      alu_src_a_s    = ASRC_RS1;
      alu_src_b_s    = BSRC_RS2;
      alu_op_s       = ALU_ADD;
      regfile_wren_s = 1'b0;
      wb_sel_s       = WB_ALU;
      dmem_wren_s    = 1'b0;
      mem_funct3_s   = 3'b000;
      case (state_r)
         ST_FETCH: begin
            if (last_s) begin
               ir_we_s      = 1'b1;
               state_next_s = ST_DECODE;
            end else begin
               ir_we_s      = 1'b0;
            end
         end
         ST_DECODE: begin
            if (opcode_s == OP_SYSTEM) begin
               set_halt_s    = 1'b1;
               state_next_s  = ST_HALT;
            end else if (!is_rv32i_op(opcode_s)) begin
               set_halt_s    = 1'b1;
               set_illegal_s = 1'b1;
               state_next_s  = ST_HALT;
            end else begin
               state_next_s  = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            alu_src_a_s = ex_a_s;
            alu_src_b_s = ex_b_s;
            alu_op_s    = ex_op_s;
            case (opcode_s)
               OP_R, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
                  state_next_s = ST_WB;
               end
               OP_LOAD, OP_STORE: begin
                  state_next_s = ST_MEM;
               end
               OP_BRANCH: begin
                  pc_we_s      = 1'b1;
                  pc_src_s     = taken_s ? PC_IMM : PC_PLUS4;
                  state_next_s = ST_FETCH;
               end
               OP_FENCE: begin
                  pc_we_s      = 1'b1;
                  state_next_s = ST_FETCH;
               end
               default: begin
                  state_next_s = ST_HALT;
               end
            endcase
         end
         ST_MEM: begin
            alu_src_a_s  = ex_a_s;
            alu_src_b_s  = ex_b_s;
            alu_op_s     = ex_op_s;
            mem_funct3_s = f3_s;
            if (opcode_s == OP_STORE) begin
               // Single strobe on the first MEM cycle; the remaining cycles only wait out latency.
               dmem_wren_s = (cnt_r == {CNT_W{1'b0}});
               if (last_s) begin
                  pc_we_s      = 1'b1;
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_MEM;
               end
            end else begin
               if (last_s) begin
                  state_next_s = ST_WB;
               end else begin
                  state_next_s = ST_MEM;
               end
            end
         end
         ST_WB: begin
            alu_src_a_s    = ex_a_s;
            alu_src_b_s    = ex_b_s;
            alu_op_s       = ex_op_s;
            regfile_wren_s = (rd_s != 5'd0);
            pc_we_s        = 1'b1;
            state_next_s   = ST_FETCH;
            case (opcode_s)
               OP_LOAD: begin
                  wb_sel_s = WB_MEM;
               end
               OP_JAL: begin
                  wb_sel_s = WB_PC4;
                  pc_src_s = PC_IMM;
               end
               OP_JALR: begin
                  wb_sel_s = WB_PC4;
                  pc_src_s = PC_ALU;
               end
               OP_LUI: begin
                  wb_sel_s = WB_IMM;
               end
               default: begin
                  wb_sel_s = WB_ALU;
               end
            endcase
         end
         ST_HALT: begin
            state_next_s = ST_HALT;
         end
         default: begin
            state_next_s = ST_HALT;
         end
      endcase
   end

   // State, wait counter and sticky halt flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_FETCH;
         cnt_r     <= {CNT_W{1'b0}};
         halted_r  <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         halted_r  <= halted_r | set_halt_s;
         illegal_r <= illegal_r | set_illegal_s;
         if (state_next_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (!last_s) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Reset gates every output directly so a store strobe dies without waiting for an edge.
   always_comb begin
      if (!reset) begin
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         pc_src       = 2'b00;
         alu_src_a    = 2'b00;
         alu_src_b    = 2'b00;
         alu_op       = 4'b0000;
         regfile_wren = 1'b0;
         wb_sel       = 2'b00;
         dmem_wren    = 1'b0;
         mem_funct3   = 3'b000;
         halted       = 1'b0;
         illegal      = 1'b0;
      end else begin
         ir_we        = ir_we_s;
         pc_we        = pc_we_s;
         pc_src       = pc_src_s;
         alu_src_a    = alu_src_a_s;
         alu_src_b    = alu_src_b_s;
         alu_op       = alu_op_s;
         regfile_wren = regfile_wren_s;
         wb_sel       = wb_sel_s;
         dmem_wren    = dmem_wren_s;
         mem_funct3   = mem_funct3_s;
         halted       = halted_r;
         illegal      = illegal_r;
      end
   end

endmodule
